// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES        = 4;
  localparam int unsigned DEFAULT_DEPTH     = 128;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    ERR
  } loaderState_e;

endpackage

// File: rtl/imem_loader_csum.sv
// Running 32-bit sum of loaded program words, compared against a supplied checksum.
module imem_loader_csum (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Clear,
  input  logic        Enable,
  input  logic [31:0] Data,
  output logic        MatchC
);

  logic [31:0] sum;

  // Accumulate accepted words modulo 2^32; Clear restarts a new load.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sum <= '0;
    end else if (Clear) begin
      sum <= '0;
    end else if (Enable) begin
      sum <= sum + Data;
    end
  end

  assign MatchC = (sum == Data);

endmodule

// File: rtl/imem_loader.sv
// Program loader: streams words into instruction memory and stalls the CPU until done.
// Optional checksum word after the program is enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Start,
  input  logic [$clog2(DEPTH):0]   WordCount,
  input  logic [31:0]              InData,
  input  logic                     InValid,
  output logic                     InReady,
  output logic [31:0]              MemAddr,
  output logic [31:0]              MemWriteData,
  output logic                     MemWrite,
  output logic                     CpuStall,
  output logic                     Done,
  output logic                     Error
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  loaderState_e state, nextState, afterLoad;
  logic [CW-1:0] count, nextCount;
  logic [CW-1:0] index, nextIndex;
  logic [CW-1:0] clampedCount;
  logic [31:0]   memAddrNext, memWriteDataNext;
  logic          memWriteNext, cpuStallNext, doneNext;
  logic          readyC;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic csumClear, csumEnable, csumMatch;
  logic errorQ, errorNext;

  imem_loader_csum uCsum (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Clear  (csumClear),
    .Enable (csumEnable),
    .Data   (InData),
    .MatchC (csumMatch)
  );

  assign afterLoad = CHECK;
  assign Error     = errorQ;
`else
  assign afterLoad = RUN;
  assign Error     = 1'b0;
`endif

  assign clampedCount = (WordCount > CW'(DEPTH)) ? CW'(DEPTH) : WordCount;
  assign InReady      = readyC;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state, handshake and next values of the registered write/status outputs.
  always_comb begin
    nextState        = state;
    nextCount        = count;
    nextIndex        = index;
    memAddrNext      = MemAddr;
    memWriteDataNext = MemWriteData;
    memWriteNext     = 1'b0;
    readyC           = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csumClear        = 1'b0;
    csumEnable       = 1'b0;
    errorNext        = errorQ;
`endif
    case (state)
      IDLE, RUN, ERR: begin
        if (Start) begin
          nextCount = clampedCount;
          nextIndex = '0;
          nextState = LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csumClear = 1'b1;
          errorNext = 1'b0;
`endif
        end
      end
      LOAD: begin
        // An empty program skips straight past the data phase.
        readyC = (count != '0);
        if (count == '0) begin
          nextState = afterLoad;
        end else if (InValid) begin
          memAddrNext      = BASE_ADDR + 32'(index) * WORD_BYTES;
          memWriteDataNext = InData;
          memWriteNext     = 1'b1;
          nextIndex        = CW'(index + 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          csumEnable       = 1'b1;
`endif
          if (index == CW'(count - 1'b1)) begin
            nextState = afterLoad;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        // One extra word is the checksum; it is compared, never written.
        readyC = 1'b1;
        if (InValid) begin
          nextState = csumMatch ? RUN : ERR;
          errorNext = !csumMatch;
        end
      end
`endif
      default: nextState = IDLE;
    endcase
    cpuStallNext = (nextState != RUN);
    doneNext     = (nextState == RUN);
  end

  // Count/index and registered memory-write and status outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count        <= '0;
      index        <= '0;
      MemAddr      <= BASE_ADDR;
      MemWriteData <= '0;
      MemWrite     <= 1'b0;
      CpuStall     <= 1'b1;
      Done         <= 1'b0;
    end else begin
      count        <= nextCount;
      index        <= nextIndex;
      MemAddr      <= memAddrNext;
      MemWriteData <= memWriteDataNext;
      MemWrite     <= memWriteNext;
      CpuStall     <= cpuStallNext;
      Done         <= doneNext;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Checksum error flag, held in ERR until the next Start.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      errorQ <= 1'b0;
    end else begin
      errorQ <= errorNext;
    end
  end
`endif

endmodule
